// File: rtl/mem_load_run_ctrl_if.sv
// Loader port bundle for mem_load_run_ctrl.
//   master : external loader (drives request/select/write/address/data, takes ack/rdata)
//   slave  : controller (takes the request, returns a one-cycle ack with read data)
interface mem_load_run_ctrl_if #(
   parameter int unsigned EA_W = 8,
   parameter int unsigned PD_W = 16
);
   logic            ext_req;
   logic            ext_sel;
   logic            ext_we;
   logic [EA_W-1:0] ext_addr;
   logic [PD_W-1:0] ext_wdata;
   logic            ext_ack;
   logic [PD_W-1:0] ext_rdata;

   modport master (
      output ext_req, ext_sel, ext_we, ext_addr, ext_wdata,
      input  ext_ack, ext_rdata
   );

   modport slave (
      input  ext_req, ext_sel, ext_we, ext_addr, ext_wdata,
      output ext_ack, ext_rdata
   );
endinterface

// File: rtl/mem_load_run_ctrl.sv
// Mode controller for the microprogrammed CPU.
// Arbitrates program/data RAM between the external loader and the core,
// runs / single-steps / halts the core, detects the halt opcode and counts
// enabled core cycles. All memory steering is mux-based.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ld (slave)                 loader request/ack port (ext_*)
//   cmd_run/cmd_step/cmd_halt  one-cycle command pulses
//   core_en                    core advance enable
//   core_op_vld/core_op        opcode from the core IR
//   core_p_*/core_d_*          core program/data RAM requests
//   pram_*/dram_*              RAM-side address/strobes/data, *_q read data (1-cycle latency)
//   state/halted/cycle_cnt     status
module mem_load_run_ctrl #(
   parameter int unsigned     PA_W    = 8,
   parameter int unsigned     PD_W    = 16,
   parameter int unsigned     DA_W    = 8,
   parameter int unsigned     DD_W    = 8,
   parameter int unsigned     EA_W    = 8,
   parameter int unsigned     OP_W    = 4,
   parameter logic [OP_W-1:0] HALT_OP = OP_W'(4'b1100),
   parameter int unsigned     CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_load_run_ctrl_if.slave ld,
   input  logic              cmd_run,
   input  logic              cmd_step,
   input  logic              cmd_halt,
   output logic              core_en,
   input  logic              core_op_vld,
   input  logic [OP_W-1:0]   core_op,
   input  logic [PA_W-1:0]   core_p_addr,
   input  logic              core_p_rd,
   input  logic [DA_W-1:0]   core_d_addr,
   input  logic              core_d_rd,
   input  logic              core_d_we,
   input  logic [DD_W-1:0]   core_d_wdata,
   output logic [PA_W-1:0]   pram_addr,
   output logic              pram_rd,
   output logic              pram_we,
   output logic [PD_W-1:0]   pram_wdata,
   output logic [DA_W-1:0]   dram_addr,
   output logic              dram_rd,
   output logic              dram_we,
   output logic [DD_W-1:0]   dram_wdata,
   input  logic [PD_W-1:0]   pram_q,
   input  logic [DD_W-1:0]   dram_q,
   output logic [1:0]        state,
   output logic              halted,
   output logic [CNT_W-1:0]  cycle_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic               sel_q, sel_d;
   logic               we_q, we_d;
   logic               halted_q, halted_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ack_c;
   logic [PD_W-1:0]    rdata_c;
   logic               halt_hit_c;
   logic               cnt_sat_c;

   // State and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sel_q    <= 1'b0;
         we_q     <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   assign halt_hit_c = core_op_vld && (core_op == HALT_OP);
   assign cnt_sat_c  = (cnt_q == {CNT_W{1'b1}});

   // Next state, counter and memory steering
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      we_d       = we_q;
      halted_d   = halted_q;
      cnt_d      = cnt_q;
      ack_c      = 1'b0;
      rdata_c    = '0;
      pram_addr  = '0;
      pram_rd    = 1'b0;
      pram_we    = 1'b0;
      pram_wdata = '0;
      dram_addr  = '0;
      dram_rd    = 1'b0;
      dram_we    = 1'b0;
      dram_wdata = '0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_run) begin
               state_d  = ST_RUN;
               cnt_d    = '0;
               halted_d = 1'b0;
            end else if (cmd_step) begin
               state_d = ST_STEP;
            end else if (ld.ext_req) begin
               state_d = ST_XFER;
               sel_d   = ld.ext_sel;
               we_d    = ld.ext_we;
               // rst_n gate keeps the RAM strobes quiet while reset is held
               if (!ld.ext_sel) begin
                  pram_addr  = ld.ext_addr[PA_W-1:0];
                  pram_we    = ld.ext_we & rst_n;
                  pram_rd    = ~ld.ext_we & rst_n;
                  pram_wdata = ld.ext_wdata;
               end else begin
                  dram_addr  = ld.ext_addr[DA_W-1:0];
                  dram_we    = ld.ext_we & rst_n;
                  dram_rd    = ~ld.ext_we & rst_n;
                  dram_wdata = ld.ext_wdata[DD_W-1:0];
               end
            end
         end
         ST_XFER: begin
            ack_c   = 1'b1;
            state_d = ST_IDLE;
            if (!we_q)
               rdata_c = sel_q ? PD_W'(dram_q) : pram_q;
         end
         ST_RUN, ST_STEP: begin
            pram_addr  = core_p_addr;
            pram_rd    = core_p_rd;
            dram_addr  = core_d_addr;
            dram_rd    = core_d_rd;
            dram_we    = core_d_we;
            dram_wdata = core_d_wdata;
            if (!cnt_sat_c)
               cnt_d = cnt_q + CNT_W'(1);
            if (halt_hit_c)
               halted_d = 1'b1;
            // STEP always ends after one cycle; RUN ends on halt opcode or cmd_halt
            if ((state_q == ST_STEP) || halt_hit_c || cmd_halt)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign core_en      = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign ld.ext_ack   = ack_c;
   assign ld.ext_rdata = rdata_c;
   assign state        = 2'(state_q);
   assign halted       = halted_q;
   assign cycle_cnt    = cnt_q;

endmodule

// File: tb/tb_mem_load_run_ctrl.sv
module tb_mem_load_run_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_load_run_ctrl_if #(.EA_W(8), .PD_W(16)) ld ();
   mem_load_run_ctrl_if #(.EA_W(8), .PD_W(16)) ld4 ();

   logic        cmd_run, cmd_step, cmd_halt;
   logic        core_op_vld;
   logic [3:0]  core_op;
   logic [7:0]  core_p_addr, core_d_addr, core_d_wdata;
   logic        core_p_rd, core_d_rd, core_d_we;
   logic        core_en;
   logic [7:0]  pram_addr, dram_addr, dram_wdata;
   logic        pram_rd, pram_we, dram_rd, dram_we;
   logic [15:0] pram_wdata;
   logic [15:0] pram_q;
   logic [7:0]  dram_q;
   logic [1:0]  state;
   logic        halted;
   logic [15:0] cycle_cnt;

   // second instance with a 4-bit counter, shares all inputs
   logic        core_en4, pram_rd4, pram_we4, dram_rd4, dram_we4, halted4;
   logic [7:0]  pram_addr4, dram_addr4, dram_wdata4;
   logic [15:0] pram_wdata4;
   logic [1:0]  state4;
   logic [3:0]  cycle_cnt4;

   assign ld4.ext_req   = ld.ext_req;
   assign ld4.ext_sel   = ld.ext_sel;
   assign ld4.ext_we    = ld.ext_we;
   assign ld4.ext_addr  = ld.ext_addr;
   assign ld4.ext_wdata = ld.ext_wdata;

   mem_load_run_ctrl dut (
      .clk(clk), .rst_n(rst_n), .ld(ld),
      .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
      .core_en(core_en), .core_op_vld(core_op_vld), .core_op(core_op),
      .core_p_addr(core_p_addr), .core_p_rd(core_p_rd),
      .core_d_addr(core_d_addr), .core_d_rd(core_d_rd), .core_d_we(core_d_we),
      .core_d_wdata(core_d_wdata),
      .pram_addr(pram_addr), .pram_rd(pram_rd), .pram_we(pram_we), .pram_wdata(pram_wdata),
      .dram_addr(dram_addr), .dram_rd(dram_rd), .dram_we(dram_we), .dram_wdata(dram_wdata),
      .pram_q(pram_q), .dram_q(dram_q),
      .state(state), .halted(halted), .cycle_cnt(cycle_cnt)
   );

   mem_load_run_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ld(ld4),
      .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
      .core_en(core_en4), .core_op_vld(core_op_vld), .core_op(core_op),
      .core_p_addr(core_p_addr), .core_p_rd(core_p_rd),
      .core_d_addr(core_d_addr), .core_d_rd(core_d_rd), .core_d_we(core_d_we),
      .core_d_wdata(core_d_wdata),
      .pram_addr(pram_addr4), .pram_rd(pram_rd4), .pram_we(pram_we4), .pram_wdata(pram_wdata4),
      .dram_addr(dram_addr4), .dram_rd(dram_rd4), .dram_we(dram_we4), .dram_wdata(dram_wdata4),
      .pram_q(pram_q), .dram_q(dram_q),
      .state(state4), .halted(halted4), .cycle_cnt(cycle_cnt4)
   );

   // RAM models, 1-cycle read latency
   logic [15:0] pmem [256];
   logic [7:0]  dmem [256];
   always @(posedge clk) begin
      if (pram_we) pmem[pram_addr] <= pram_wdata;
      if (pram_rd) pram_q <= pmem[pram_addr];
      if (dram_we) dmem[dram_addr] <= dram_wdata;
      if (dram_rd) dram_q <= dmem[dram_addr];
   end

   int n_tot  = 0;
   int n_pass = 0;
   logic [15:0] exp_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Scoreboard monitor: every ack pops one expected read value
   always @(negedge clk) begin
      if (rst_n === 1'b1 && ld.ext_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_ack: got ack with rdata 0x%0h expected no ack", ld.ext_rdata);
         end else begin
            chk("ext_rdata", 32'(ld.ext_rdata), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic req_on(input logic sel, input logic we, input logic [7:0] addr,
                         input logic [15:0] wdata);
      ld.ext_req = 1'b1; ld.ext_sel = sel; ld.ext_we = we;
      ld.ext_addr = addr; ld.ext_wdata = wdata;
   endtask

   // Loader transfer from IDLE: strobes in accept cycle, ack one cycle later
   task automatic xfer(input logic sel, input logic we, input logic [7:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rd);
      exp_q.push_back(we ? 16'h0000 : exp_rd);
      req_on(sel, we, addr, wdata);
      mid();
      chk("strobes", 32'({pram_we, pram_rd, dram_we, dram_rd}),
          32'({~sel & we, ~sel & ~we, sel & we, sel & ~we}));
      if (!sel) chk("pram_addr", 32'(pram_addr), 32'(addr));
      else      chk("dram_addr", 32'(dram_addr), 32'(addr));
      if (we && !sel) chk("pram_wdata", 32'(pram_wdata), 32'(wdata));
      if (we && sel)  chk("dram_wdata", 32'(dram_wdata), 32'(wdata[7:0]));
      chk("ack_early", 32'(ld.ext_ack), 32'd0);
      mid();
      chk("ack_latency", 32'(ld.ext_ack), 32'd1);
      cyc();
      ld.ext_req = 1'b0;
   endtask

   task automatic pulse_run();
      cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      ld.ext_req = 1'b0; ld.ext_sel = 1'b0; ld.ext_we = 1'b0;
      ld.ext_addr = '0; ld.ext_wdata = '0;
      cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
      core_op_vld = 1'b0; core_op = '0;
      core_p_addr = '0; core_p_rd = 1'b0; core_d_addr = '0;
      core_d_rd = 1'b0; core_d_we = 1'b0; core_d_wdata = '0;
      repeat (3) cyc();
      mid();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_cnt", 32'(cycle_cnt), 32'd0);
      chk("rst_core_en", 32'(core_en), 32'd0);
      chk("rst_ack_rdata", 32'({ld.ext_ack, ld.ext_rdata}), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // loader transfers
      xfer(1'b0, 1'b1, 8'h05, 16'hB123, 16'h0);
      xfer(1'b0, 1'b0, 8'h05, 16'h0, 16'hB123);
      xfer(1'b1, 1'b1, 8'hFF, 16'h01A5, 16'h0);
      xfer(1'b1, 1'b0, 8'hFF, 16'h0, 16'h00A5);
      xfer(1'b0, 1'b1, 8'h00, 16'h7E5A, 16'h0);
      xfer(1'b0, 1'b0, 8'h00, 16'h0, 16'h7E5A);

      // single step
      cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
      mid();
      chk("step_core_en", 32'(core_en), 32'd1);
      chk("step_state", 32'(state), 32'd3);
      cyc(); mid();
      chk("step_done_core_en", 32'(core_en), 32'd0);
      chk("step_done_state", 32'(state), 32'd0);
      chk("step_cnt", 32'(cycle_cnt), 32'd1);

      // step with halt opcode and cmd_halt together
      cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
      core_op_vld = 1'b1; core_op = 4'hC; cmd_halt = 1'b1;
      cyc();
      core_op_vld = 1'b0; core_op = '0; cmd_halt = 1'b0;
      mid();
      chk("step_halt_halted", 32'(halted), 32'd1);
      chk("step_halt_cnt", 32'(cycle_cnt), 32'd2);
      chk("step_halt_state", 32'(state), 32'd0);

      // free run, halt opcode on the 10th enabled cycle
      pulse_run();
      mid();
      chk("run_cleared_halted", 32'(halted), 32'd0);
      chk("run_cleared_cnt", 32'(cycle_cnt), 32'd0);
      chk("run_core_en", 32'(core_en), 32'd1);
      for (int i = 2; i <= 10; i++) begin
         cyc();
         core_op_vld = 1'b0; cmd_step = 1'b0;
         if (i == 3) cmd_step = 1'b1;
         if (i == 5) begin core_op_vld = 1'b1; core_op = 4'hD; end
         if (i == 6) begin mid(); chk("run_ignores_step_and_op", 32'(state), 32'd2); end
      end
      core_op_vld = 1'b1; core_op = 4'hC;
      mid();
      chk("run_cnt_9", 32'(cycle_cnt), 32'd9);
      cyc();
      core_op_vld = 1'b0; core_op = '0;
      mid();
      chk("halt_core_en", 32'(core_en), 32'd0);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_cnt", 32'(cycle_cnt), 32'd10);
      chk("halt_state", 32'(state), 32'd0);
      cyc();

      // loader request held off during RUN, served after cmd_halt
      pulse_run();
      core_p_addr = 8'h33; core_p_rd = 1'b1;
      core_d_addr = 8'h44; core_d_we = 1'b1; core_d_wdata = 8'h5A;
      exp_q.push_back(16'hB123);
      req_on(1'b0, 1'b0, 8'h05, 16'h0);
      mid();
      chk("core_pass_p", 32'({pram_rd, pram_we, pram_addr}), 32'({1'b1, 1'b0, 8'h33}));
      chk("core_pass_d", 32'({dram_we, dram_addr, dram_wdata}), 32'({1'b1, 8'h44, 8'h5A}));
      for (int i = 0; i < 3; i++) begin
         cyc(); mid();
         chk("run_no_ack", 32'({ld.ext_ack, state}), 32'({1'b0, 2'd2}));
      end
      cyc();
      core_p_rd = 1'b0; core_d_we = 1'b0; core_p_addr = '0; core_d_addr = '0;
      cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
      mid();
      chk("cmd_halt_state", 32'(state), 32'd0);
      chk("cmd_halt_halted", 32'(halted), 32'd0);
      chk("post_halt_accept", 32'({ld.ext_ack, pram_rd, pram_addr}), 32'({1'b0, 1'b1, 8'h05}));
      mid();
      chk("post_halt_ack", 32'(ld.ext_ack), 32'd1);
      cyc();
      ld.ext_req = 1'b0;

      // cmd_halt and halt opcode in the same RUN cycle
      pulse_run();
      cmd_halt = 1'b1; core_op_vld = 1'b1; core_op = 4'hC;
      cyc();
      cmd_halt = 1'b0; core_op_vld = 1'b0; core_op = '0;
      mid();
      chk("both_halt_halted", 32'(halted), 32'd1);
      chk("both_halt_state", 32'(state), 32'd0);

      // reset asserted in the XFER cycle, request kept high
      cyc();
      req_on(1'b1, 1'b0, 8'hFF, 16'h0);
      cyc();
      rst_n = 1'b0;
      mid();
      chk("rst_xfer_state", 32'(state), 32'd0);
      chk("rst_xfer_ack", 32'(ld.ext_ack), 32'd0);
      chk("rst_xfer_strobes", 32'({pram_rd, pram_we, dram_rd, dram_we}), 32'd0);
      cyc(); mid();
      chk("rst_xfer_status", 32'({halted, cycle_cnt}), 32'd0);
      cyc();
      ld.ext_req = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();

      // 20-cycle run: 16-bit counter reaches 20, 4-bit counter saturates at 15
      pulse_run();
      repeat (19) cyc();
      cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
      mid();
      chk("run20_cnt16", 32'(cycle_cnt), 32'd20);
      chk("run20_cnt4_sat", 32'(cycle_cnt4), 32'd15);
      chk("run20_state", 32'(state4), 32'd0);

      repeat (3) cyc();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
